// File: rtl/led_row_ctrl_pkg.sv
// Shared types and defaults for the LED panel row controller.
package led_row_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_DISPLAY = 2'd0,
    ST_BLANK   = 2'd1,
    ST_LATCH   = 2'd2,
    ST_ADVANCE = 2'd3
  } row_state_t;

  localparam int PWM_W = 8;
  localparam int DEF_PIXELS = 64;
  localparam int DEF_ROWS = 16;
  localparam logic [PWM_W-1:0] DEF_PWM_MAX = 8'd254;

  function automatic logic [PWM_W-1:0] pwm_next(input logic [PWM_W-1:0] v,
                                                input logic [PWM_W-1:0] vmax);
    return (v == vmax) ? {PWM_W{1'b0}} : v + PWM_W'(1);
  endfunction

endpackage

// File: rtl/led_row_ctrl_pix_counter.sv
// Modulo-PIXELS pixel-pair counter; flags row_end on the strobe that completes a row.
module led_pix_counter
  import led_row_ctrl_pkg::*;
#(
  parameter int PIXELS = DEF_PIXELS
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic i_strobe,
  output logic o_row_end
);

  localparam int CW = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  logic [CW-1:0] r_pix_cnt;
  logic          w_last;

  assign w_last    = (r_pix_cnt == CW'(PIXELS - 1));
  assign o_row_end = i_strobe & w_last;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_pix_cnt <= '0;
    end else if (i_strobe) begin
      r_pix_cnt <= w_last ? '0 : r_pix_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_row_ctrl.sv
// Row scan controller for a HUB75-style panel: blank, latch, advance row, frame/PWM sequencing.
module led_row_ctrl
  import led_row_ctrl_pkg::*;
#(
  parameter int               PIXELS  = DEF_PIXELS,
  parameter int               ROWS    = DEF_ROWS,
  parameter logic [PWM_W-1:0] PWM_MAX = DEF_PWM_MAX
) (
  input  logic                     in_clk,
  input  logic                     in_rst,
  input  logic                     last_phase_strobe,
  output logic [PWM_W-1:0]         pwm_value,
  output logic [$clog2(ROWS)-1:0]  row_addr,
  output logic                     led_lat,
  output logic                     led_oe_n,
  output logic                     al422_rrst_n,
  output logic                     frame_start,
  output logic                     overrun_err
);

  localparam int RW = $clog2(ROWS);

  row_state_t       r_state, w_state_nxt;
  logic [RW-1:0]    r_row_cnt, w_row_cnt_nxt;
  logic [RW-1:0]    r_row_addr, w_row_addr_nxt;
  logic [PWM_W-1:0] r_pwm, w_pwm_nxt;
  logic             r_lat, w_lat_nxt;
  logic             r_oe_n, w_oe_n_nxt;
  logic             r_rrst_n, w_rrst_n_nxt;
  logic             r_fs, w_fs_nxt;
  logic             r_ovr, w_ovr_nxt;
  logic             w_row_end;

  led_pix_counter #(.PIXELS(PIXELS)) u_pix_counter (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .i_strobe  (last_phase_strobe),
    .o_row_end (w_row_end)
  );

  // Outputs are computed one state ahead so each registered output lines up with its state.
  always_comb begin
    w_state_nxt    = r_state;
    w_row_cnt_nxt  = r_row_cnt;
    w_row_addr_nxt = r_row_addr;
    w_pwm_nxt      = r_pwm;
    w_lat_nxt      = 1'b0;
    w_oe_n_nxt     = r_oe_n;
    w_rrst_n_nxt   = 1'b1;
    w_fs_nxt       = 1'b0;
    w_ovr_nxt      = r_ovr | (w_row_end & (r_state != ST_DISPLAY));
    case (r_state)
      ST_DISPLAY: begin
        if (w_row_end) begin
          w_state_nxt = ST_BLANK;
          w_oe_n_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_DISPLAY;
        end
      end
      ST_BLANK: begin
        w_state_nxt = ST_LATCH;
        w_oe_n_nxt  = 1'b1;
        w_lat_nxt   = 1'b1;
      end
      ST_LATCH: begin
        w_state_nxt    = ST_ADVANCE;
        w_oe_n_nxt     = 1'b1;
        w_row_addr_nxt = r_row_cnt;
        w_row_cnt_nxt  = r_row_cnt + RW'(1);
        // Last row of the frame: rewind the AL422 and step the PWM threshold.
        if (r_row_cnt == RW'(ROWS - 1)) begin
          w_rrst_n_nxt = 1'b0;
          w_fs_nxt     = 1'b1;
          w_pwm_nxt    = pwm_next(r_pwm, PWM_MAX);
        end else begin
          w_rrst_n_nxt = 1'b1;
        end
      end
      ST_ADVANCE: begin
        w_state_nxt = ST_DISPLAY;
        w_oe_n_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = ST_DISPLAY;
        w_oe_n_nxt  = 1'b1;
      end
    endcase
  end

  // Oe_n holds high after reset until the first row has been latched and addressed.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state    <= ST_DISPLAY;
      r_row_cnt  <= '0;
      r_row_addr <= '0;
      r_pwm      <= '0;
      r_lat      <= 1'b0;
      r_oe_n     <= 1'b1;
      r_rrst_n   <= 1'b0;
      r_fs       <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_row_cnt  <= w_row_cnt_nxt;
      r_row_addr <= w_row_addr_nxt;
      r_pwm      <= w_pwm_nxt;
      r_lat      <= w_lat_nxt;
      r_oe_n     <= w_oe_n_nxt;
      r_rrst_n   <= w_rrst_n_nxt;
      r_fs       <= w_fs_nxt;
      r_ovr      <= w_ovr_nxt;
    end
  end

  assign pwm_value    = r_pwm;
  assign row_addr     = r_row_addr;
  assign led_lat      = r_lat;
  assign led_oe_n     = r_oe_n;
  assign al422_rrst_n = r_rrst_n;
  assign frame_start  = r_fs;
  assign overrun_err  = r_ovr;

endmodule
